// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register carrying a writeback bundle.
// Handles flush, bubble insertion and stall-hold, and keeps saturating retire/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SB_W        = 40,
  parameter int unsigned STALL_W     = 6,
  parameter int unsigned STAGE_IDX   = 4,
  parameter int unsigned SUPPRESS_R0 = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic              in_whilo,
  input  logic [SB_W-1:0]   in_sb,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
  output logic              out_whilo,
  output logic [SB_W-1:0]   out_sb,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (STAGE_IDX >= STALL_W) begin : g_bad_stage_idx
    $error("pipe_stage_reg: STAGE_IDX must be less than STALL_W");
  end

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_NOP,
    ACT_CAPTURE
  } act_e;

  logic s_here;
  logic s_next;
  logic stall_unused;
  act_e act;
  logic r0_dst;

  assign s_here       = stall[STAGE_IDX];
  assign stall_unused = ^stall;

  // The last stage has no downstream stall bit; treat it as never stalled.
  if (STAGE_IDX + 1 < STALL_W) begin : g_next_stall
    assign s_next = stall[STAGE_IDX+1];
  end else begin : g_last_stage
    assign s_next = 1'b0;
  end

  assign r0_dst = (SUPPRESS_R0 != 0) && (in_wd == '0);

  always_comb begin
    act = ACT_HOLD;
    if (flush) begin
      act = ACT_NOP;
    end else if (s_here && !s_next) begin
      act = ACT_NOP;
    end else if (!s_here) begin
      act = ACT_CAPTURE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_wd    <= '0;
      out_wreg  <= 1'b0;
      out_wdata <= '0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_whilo <= 1'b0;
      out_sb    <= '0;
    end else begin
      unique case (act)
        ACT_NOP: begin
          out_valid <= 1'b0;
          out_wd    <= '0;
          out_wreg  <= 1'b0;
          out_wdata <= '0;
          out_hi    <= '0;
          out_lo    <= '0;
          out_whilo <= 1'b0;
          out_sb    <= '0;
        end
        ACT_CAPTURE: begin
          // Invalid slots keep their data but never write architectural state.
          out_valid <= in_valid;
          out_wd    <= in_wd;
          out_wreg  <= in_valid && in_wreg && !r0_dst;
          out_wdata <= in_wdata;
          out_hi    <= in_hi;
          out_lo    <= in_lo;
          out_whilo <= in_valid && in_whilo;
          out_sb    <= in_sb;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (act == ACT_CAPTURE && in_valid && retire_cnt != '1) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (act == ACT_NOP && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two parameterisations share one stimulus stream,
// a behavioural model predicts each edge and a monitor compares after every clock.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_wd = '0;
  logic        in_wreg = 1'b0;
  logic [31:0] in_wdata = '0;
  logic [31:0] in_hi = '0;
  logic [31:0] in_lo = '0;
  logic        in_whilo = 1'b0;
  logic [39:0] in_sb = '0;

  logic        o0_valid, o0_wreg, o0_whilo;
  logic [4:0]  o0_wd;
  logic [31:0] o0_wdata, o0_hi, o0_lo;
  logic [39:0] o0_sb;
  logic [31:0] o0_retire, o0_bubble;

  logic        o1_valid, o1_wreg, o1_whilo;
  logic [4:0]  o1_wd;
  logic [31:0] o1_wdata, o1_hi, o1_lo;
  logic [39:0] o1_sb;
  logic [3:0]  o1_retire, o1_bubble;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGE_IDX(4), .SUPPRESS_R0(1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo), .in_sb(in_sb),
    .out_valid(o0_valid), .out_wd(o0_wd), .out_wreg(o0_wreg), .out_wdata(o0_wdata),
    .out_hi(o0_hi), .out_lo(o0_lo), .out_whilo(o0_whilo), .out_sb(o0_sb),
    .retire_cnt(o0_retire), .bubble_cnt(o0_bubble)
  );

  pipe_stage_reg #(.STAGE_IDX(5), .SUPPRESS_R0(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo), .in_sb(in_sb),
    .out_valid(o1_valid), .out_wd(o1_wd), .out_wreg(o1_wreg), .out_wdata(o1_wdata),
    .out_hi(o1_hi), .out_lo(o1_lo), .out_whilo(o1_whilo), .out_sb(o1_sb),
    .retire_cnt(o1_retire), .bubble_cnt(o1_bubble)
  );

  typedef struct {
    logic              valid;
    logic [4:0]        wd;
    logic              wreg;
    logic [31:0]       wdata;
    logic [31:0]       hi;
    logic [31:0]       lo;
    logic              whilo;
    logic [39:0]       sb;
    longint unsigned   retire;
    longint unsigned   bubble;
  } exp_t;

  exp_t m0, m1;
  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t zero_state();
    exp_t z;
    z.valid = 0; z.wd = 0; z.wreg = 0; z.wdata = 0; z.hi = 0; z.lo = 0;
    z.whilo = 0; z.sb = 0; z.retire = 0; z.bubble = 0;
    return z;
  endfunction

  // Next visible state of one register given the current inputs.
  function automatic exp_t model(exp_t s, int unsigned sidx, bit sup, longint unsigned cmax);
    exp_t n = s;
    logic [5:0] sv = stall;
    bit sh = sv[sidx];
    bit sn = (sidx + 1 < 6) ? sv[sidx+1] : 1'b0;
    if (flush || (sh && !sn)) begin
      n = zero_state();
      n.retire = s.retire;
      n.bubble = (s.bubble < cmax) ? s.bubble + 1 : cmax;
    end else if (!sh) begin
      n.valid = in_valid;
      n.wd    = in_wd;
      n.wreg  = in_valid && in_wreg && !(sup && in_wd == 0);
      n.wdata = in_wdata;
      n.hi    = in_hi;
      n.lo    = in_lo;
      n.whilo = in_valid && in_whilo;
      n.sb    = in_sb;
      if (in_valid && s.retire < cmax) n.retire = s.retire + 1;
    end
    if (cnt_clr) begin
      n.retire = 0;
      n.bubble = 0;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t e, exp_t a);
    chk({tag, ".valid"}, 64'(a.valid), 64'(e.valid));
    chk({tag, ".wd"}, 64'(a.wd), 64'(e.wd));
    chk({tag, ".wreg"}, 64'(a.wreg), 64'(e.wreg));
    chk({tag, ".wdata"}, 64'(a.wdata), 64'(e.wdata));
    chk({tag, ".hi"}, 64'(a.hi), 64'(e.hi));
    chk({tag, ".lo"}, 64'(a.lo), 64'(e.lo));
    chk({tag, ".whilo"}, 64'(a.whilo), 64'(e.whilo));
    chk({tag, ".sb"}, 64'(a.sb), 64'(e.sb));
    chk({tag, ".retire"}, a.retire, e.retire);
    chk({tag, ".bubble"}, a.bubble, e.bubble);
  endtask

  function automatic exp_t snap0();
    exp_t a;
    a.valid = o0_valid; a.wd = o0_wd; a.wreg = o0_wreg; a.wdata = o0_wdata;
    a.hi = o0_hi; a.lo = o0_lo; a.whilo = o0_whilo; a.sb = o0_sb;
    a.retire = 64'(o0_retire); a.bubble = 64'(o0_bubble);
    return a;
  endfunction

  function automatic exp_t snap1();
    exp_t a;
    a.valid = o1_valid; a.wd = o1_wd; a.wreg = o1_wreg; a.wdata = o1_wdata;
    a.hi = o1_hi; a.lo = o1_lo; a.whilo = o1_whilo; a.sb = o1_sb;
    a.retire = 64'(o1_retire); a.bubble = 64'(o1_bubble);
    return a;
  endfunction

  // Monitor: every edge out of reset must have a prediction waiting.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        chk("scoreboard_underflow", 64'(q0.size()), 64'd1);
      end else begin
        cmp("dut0", q0.pop_front(), snap0());
        cmp("dut1", q1.pop_front(), snap1());
      end
    end
  end

  task automatic rand_payload();
    in_wd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    in_wreg  = 1'($urandom);
    in_wdata = $urandom;
    in_hi    = $urandom;
    in_lo    = $urandom;
    in_whilo = 1'($urandom);
    in_sb    = {8'($urandom), 32'($urandom)};
    in_valid = 1'($urandom);
  endtask

  // Issue the current inputs for the coming edge and record the predictions.
  task automatic issue();
    m0 = model(m0, 4, 1'b1, 64'hFFFF_FFFF);
    m1 = model(m1, 5, 1'b0, 64'd15);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".d0valid"}, 64'(o0_valid), 64'd0);
    chk({tag, ".d0wdata"}, 64'(o0_wdata), 64'd0);
    chk({tag, ".d0sb"}, 64'(o0_sb), 64'd0);
    chk({tag, ".d0retire"}, 64'(o0_retire), 64'd0);
    chk({tag, ".d0bubble"}, 64'(o0_bubble), 64'd0);
    chk({tag, ".d1wreg"}, 64'(o1_wreg), 64'd0);
    chk({tag, ".d1retire"}, 64'(o1_retire), 64'd0);
  endtask

  task automatic drive(logic [5:0] st, logic fl, logic v, logic [4:0] wd, logic wr, logic [31:0] wdat, logic wh);
    @(negedge clk);
    rand_payload();
    stall = st; flush = fl; cnt_clr = 1'b0;
    in_valid = v; in_wd = wd; in_wreg = wr; in_wdata = wdat; in_whilo = wh;
    issue();
  endtask

  initial begin
    m0 = zero_state();
    m1 = zero_state();
    rand_payload();
    stall = 6'($urandom);
    #3;
    check_all_zero("reset_initial");

    @(negedge clk);
    rst = 1'b0;
    stall = '0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_wd = 5'd3; in_wreg = 1'b1; in_wdata = 32'h1234_5678;
    issue();
    settle();
    chk("first.wd", 64'(o0_wd), 64'd3);
    chk("first.wreg", 64'(o0_wreg), 64'd1);
    chk("first.wdata", 64'(o0_wdata), 64'h1234_5678);
    chk("first.retire", 64'(o0_retire), 64'd1);

    drive(6'b001111, 1'b0, 1'b1, 5'd7, 1'b1, 32'hA5A5_0001, 1'b1);
    drive(6'b011111, 1'b0, 1'b1, 5'd8, 1'b1, 32'hA5A5_0002, 1'b1);
    settle();
    chk("bubble.valid", 64'(o0_valid), 64'd0);
    chk("bubble.cnt", 64'(o0_bubble), 64'd1);
    for (int i = 0; i < 3; i++) drive(6'b111111, 1'b0, 1'b1, 5'd9, 1'b1, 32'hA5A5_0003, 1'b1);
    drive(6'b000000, 1'b0, 1'b1, 5'd10, 1'b1, 32'hCAFE_0001, 1'b0);
    drive(6'b000000, 1'b1, 1'b1, 5'd11, 1'b1, 32'hCAFE_0002, 1'b1);
    drive(6'b000000, 1'b0, 1'b1, 5'd12, 1'b1, 32'hCAFE_0003, 1'b1);
    drive(6'b111111, 1'b1, 1'b1, 5'd13, 1'b1, 32'hCAFE_0004, 1'b1);
    settle();
    chk("flush_stalled.valid", 64'(o0_valid), 64'd0);
    chk("flush_stalled.wdata", 64'(o0_wdata), 64'd0);

    drive(6'b000000, 1'b0, 1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    settle();
    chk("r0.sup_wreg", 64'(o0_wreg), 64'd0);
    chk("r0.sup_wdata", 64'(o0_wdata), 64'hDEAD_BEEF);
    chk("r0.nosup_wreg", 64'(o1_wreg), 64'd1);

    drive(6'b000000, 1'b0, 1'b0, 5'd5, 1'b1, 32'h0BAD_0001, 1'b1);
    settle();
    chk("invalid.wreg", 64'(o0_wreg), 64'd0);
    chk("invalid.whilo", 64'(o0_whilo), 64'd0);

    for (int i = 0; i < 20; i++) drive(6'b000000, 1'b0, 1'b1, 5'd4, 1'b1, 32'($urandom), 1'b0);
    settle();
    chk("sat.retire4", 64'(o1_retire), 64'd15);

    @(negedge clk);
    rand_payload();
    stall = '0; flush = 1'b0; cnt_clr = 1'b1; in_valid = 1'b1; in_wdata = 32'h5151_7272;
    issue();
    settle();
    chk("clr.retire", 64'(o0_retire), 64'd0);
    chk("clr.wdata", 64'(o0_wdata), 64'h5151_7272);

    // Asynchronous reset while stalled and flushing.
    @(negedge clk);
    stall = 6'b111111; flush = 1'($urandom); cnt_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    m0 = zero_state();
    m1 = zero_state();
    @(negedge clk);
    rst = 1'b0;
    rand_payload();
    issue();

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rand_payload();
      stall   = 6'($urandom);
      flush   = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 40) == 0);
      issue();
    end

    settle();
    @(negedge clk);
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
